// File: rtl/fcd_pkg.sv
// fcd_pkg: shared constants and elaboration-time helpers for the finger-count decoder.
package fcd_pkg;
  localparam int SYN_NONE = 0;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int parity_count(input int k);
    int p = 0;
    for (int i = 0; i < 8; i++) if ((1 << p) < k + p + 1) p++;
    return p;
  endfunction
  // Hamming position (1-based) of info bit idx: non-power-of-two slots in ascending order.
  function automatic int data_pos(input int k, input int idx);
    int n = 0;
    int pos = 0;
    for (int p = 1; p <= k + parity_count(k); p++)
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = p;
        n++;
      end
    return pos;
  endfunction
endpackage

// File: rtl/fcd_map.sv
// fcd_map: K-bit finger pattern to count (thermometer 1..K, high-run K+1..2K-1, zero 2K) or invalid.
module fcd_map import fcd_pkg::*; #(
  parameter int K = 5,
  parameter int RES_W = clog2(2 * K + 1)
) (
  input  logic [K-1:0]     pat_i,
  output logic [RES_W-1:0] result_o,
  output logic             invalid_o
);
  always_comb begin
    result_o = '0;
    invalid_o = 1'b1;
    if (pat_i == '0) begin
      result_o = RES_W'(2 * K);
      invalid_o = 1'b0;
    end
    for (int n = 1; n <= K; n++)
      if (pat_i == ({K{1'b1}} >> (K - n))) begin
        result_o = RES_W'(n);
        invalid_o = 1'b0;
      end
    for (int m = 1; m < K; m++)
      if (pat_i == ({K{1'b1}} << m)) begin
        result_o = RES_W'(K + m);
        invalid_o = 1'b0;
      end
  end
endmodule

// File: rtl/finger_count_decoder_pipe.sv
// finger_count_decoder_pipe: 2-stage Hamming-correcting finger-count decoder with valid/ready
// handshake and saturating error statistics.
module finger_count_decoder_pipe import fcd_pkg::*; #(
  parameter int K = 5,
  parameter int CNT_W = 8,
  localparam int P = parity_count(K),
  localparam int CW_W = K + P,
  localparam int RES_W = clog2(2 * K + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_corrected,
  output logic             out_uncorr,
  output logic             out_invalid,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorr
);
  logic             s1_valid_q, s2_valid_q, s1_adv, s2_adv, done;
  logic [P-1:0]     syn_d, s1_syn_q;
  logic [K-1:0]     data_d, s1_data_q, fix_data;
  logic [RES_W-1:0] map_result, result_d, s2_result_q;
  logic             map_invalid, corr_d, uncorr_d, invalid_d;
  logic             s2_corr_q, s2_uncorr_q, s2_invalid_q;
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;

  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign done = s2_valid_q && out_ready;

  always_comb begin
    syn_d = P'(SYN_NONE);
    for (int i = 1; i <= CW_W; i++) syn_d = syn_d ^ (in_cw[i-1] ? P'(i) : P'(0));
  end

  // A syndrome pointing at a parity slot leaves the data untouched but still counts as corrected.
  for (genvar g = 0; g < K; g++) begin : g_data
    localparam int POS = data_pos(K, g);
    assign data_d[g] = in_cw[POS-1];
    assign fix_data[g] = s1_data_q[g] ^ (s1_syn_q == P'(POS));
  end

  assign corr_d = (s1_syn_q != P'(SYN_NONE)) && (s1_syn_q <= P'(CW_W));
  assign uncorr_d = s1_syn_q > P'(CW_W);

  fcd_map #(.K(K), .RES_W(RES_W)) u_map (
    .pat_i    (fix_data),
    .result_o (map_result),
    .invalid_o(map_invalid)
  );

  assign result_d = uncorr_d ? '0 : map_result;
  assign invalid_d = !uncorr_d && map_invalid;
  assign cnt_corr_d = clr_stats ? '0 : cnt_corr_q + CNT_W'(done && s2_corr_q && !(&cnt_corr_q));
  assign cnt_uncorr_d = clr_stats ? '0 : cnt_uncorr_q + CNT_W'(done && s2_uncorr_q && !(&cnt_uncorr_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_syn_q <= '0;
      s1_data_q <= '0;
      s2_valid_q <= 1'b0;
      s2_result_q <= '0;
      s2_corr_q <= 1'b0;
      s2_uncorr_q <= 1'b0;
      s2_invalid_q <= 1'b0;
      cnt_corr_q <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s1_adv && in_valid) begin
        s1_syn_q <= syn_d;
        s1_data_q <= data_d;
      end
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        s2_result_q <= result_d;
        s2_corr_q <= corr_d;
        s2_uncorr_q <= uncorr_d;
        s2_invalid_q <= invalid_d;
      end
      cnt_corr_q <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_corrected = s2_corr_q;
  assign out_uncorr = s2_uncorr_q;
  assign out_invalid = s2_invalid_q;
  assign cnt_corrected = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
endmodule

// File: tb/tb_finger_count_decoder_pipe.sv
// tb_finger_count_decoder_pipe: randomized scoreboard bench with a behavioural Hamming/finger model.
module tb_finger_count_decoder_pipe;
  localparam int K = 5;
  localparam int CW = 9;
  localparam int CMAX = 255;

  typedef struct {
    int res;
    bit corr;
    bit unc;
    bit inv;
    int acc;
    bit ex;
  } exp_t;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, clr_stats;
  logic [CW-1:0] in_cw;
  logic [3:0] out_result;
  logic out_corrected, out_uncorr, out_invalid;
  logic [7:0] cnt_corrected, cnt_uncorr;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_corr = 0, m_unc = 0;
  bit stall = 0, rand_ready = 0, ready_force = 1, exact_lat = 0;

  finger_count_decoder_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_corrected(out_corrected), .out_uncorr(out_uncorr), .out_invalid(out_invalid),
    .clr_stats(clr_stats), .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom % 3 != 0) : ready_force;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode straight from the rules: syndrome as XOR of set indices, then classify the info word by popcount.
  function automatic exp_t model(input logic [CW-1:0] cw);
    exp_t e = '{default: 0};
    int syn = 0, d = 0, idx = 0, ones;
    for (int p = 1; p <= CW; p++) if (cw[p-1]) syn ^= p;
    if (syn > CW) begin
      e.unc = 1;
      return e;
    end
    if (syn != 0) begin
      cw[syn-1] = ~cw[syn-1];
      e.corr = 1;
    end
    for (int p = 1; p <= CW; p++)
      if ((p & (p - 1)) != 0) begin
        d |= (cw[p-1] ? 1 : 0) << idx;
        idx++;
      end
    ones = $countones(d);
    if (d == 0) e.res = 2 * K;
    else if (d == (1 << ones) - 1) e.res = ones;
    else if (d == ((1 << K) - 1) - ((1 << (K - ones)) - 1)) e.res = 2 * K - ones;
    else e.inv = 1;
    return e;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [K-1:0] d);
    logic [CW-1:0] cw = '0;
    int idx = 0, syn = 0;
    for (int p = 1; p <= CW; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[idx];
        idx++;
      end
    for (int p = 1; p <= CW; p++) if (cw[p-1]) syn ^= p;
    for (int j = 0; (1 << j) <= CW; j++) if (syn[j]) cw[(1 << j) - 1] = 1'b1;
    return cw;
  endfunction

  function automatic logic [CW-1:0] rand_cw();
    logic [K-1:0] d;
    logic [CW-1:0] cw;
    int r = $urandom_range(0, 2 * K - 1);
    d = r < K ? K'((1 << (r + 1)) - 1) : r < 2 * K - 1 ? K'(((1 << K) - 1) & ~((1 << (r - K + 1)) - 1)) : '0;
    case ($urandom % 4)
      0: cw = encode(d);
      1: cw = encode(K'($urandom));
      2: begin
        cw = encode(K'($urandom));
        cw[$urandom_range(0, CW - 1)] ^= 1'b1;
      end
      default: cw = CW'($urandom);
    endcase
    return cw;
  endfunction

  task automatic push(input logic [CW-1:0] cw);
    exp_t e = model(cw);
    e.acc = cyc;
    e.ex = exact_lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [CW-1:0] cw);
    bit ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_cw = cw;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push(cw);
        ok = 1;
      end else @(posedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_corr = 0;
      m_unc = 0;
      stall = 0;
    end else begin
      exp_t e;
      chk("cnt_corrected", cnt_corrected, m_corr);
      chk("cnt_uncorr", cnt_uncorr, m_unc);
      if (stall) chk("stall_valid_held", out_valid, 1);
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = sb[0];
          chk("result", out_result, e.res);
          chk("corrected", out_corrected, e.corr);
          chk("uncorr", out_uncorr, e.unc);
          chk("invalid", out_invalid, e.inv);
          if (!stall) begin
            if (e.ex) chk("latency", cyc - e.acc, 2);
            else chk("latency_min2", (cyc - e.acc) >= 2, 1);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            if (e.corr && m_corr < CMAX) m_corr++;
            if (e.unc && m_unc < CMAX) m_unc++;
          end
        end
      end
      if (clr_stats) begin
        m_corr = 0;
        m_unc = 0;
      end
      stall = out_valid && !out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] bp[4];
    int k;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_cw = '0;
    clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_flags", {out_corrected, out_uncorr, out_invalid}, 0);
    chk("reset_cnt", {cnt_corrected, cnt_uncorr}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    exact_lat = 1;
    send(9'h007);
    send(9'h1FE);
    send(9'h000);
    send(9'h1FF);
    send(9'h140);
    send(9'h1CD);
    idle(1);
    drain();
    exact_lat = 0;

    ready_force = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) bp[i] = rand_cw();
    k = 0;
    in_valid = 1'b1;
    in_cw = bp[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push(bp[k]);
        k++;
      end
      @(posedge clk);
      #1;
      in_cw = bp[k];
    end
    @(negedge clk);
    chk("bp_accepted", k, 2);
    chk("bp_in_ready", in_ready, 0);
    ready_force = 1;
    for (int c = 0; c < 50 && k < 4; c++) begin
      @(posedge clk);
      #1;
      in_cw = bp[k];
      @(negedge clk);
      if (in_ready) begin
        push(bp[k]);
        k++;
      end
    end
    chk("bp_all_sent", k, 4);
    idle(1);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 == 0) idle(1);
      else send(rand_cw());
    end
    idle(1);
    rand_ready = 0;
    ready_force = 1;
    drain();

    for (int i = 0; i < 260; i++) send(9'h1FF);
    idle(1);
    drain();
    @(negedge clk);
    chk("cnt_saturated", cnt_corrected, 255);

    send(9'h1FF);
    idle(1);
    @(posedge clk);
    #1 clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_beats_inc", cnt_corrected, 0);

    send(rand_cw());
    send(rand_cw());
    send(rand_cw());
    @(posedge clk);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_result", out_result, 0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_out_valid", out_valid, 0);
    exact_lat = 1;
    send(9'h1FF);
    send(9'h140);
    send(encode(5'b11000));
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/finger_count_decoder_pipe.md
Name: finger_count_decoder_pipe

Overview:
Streaming successor to the combinational finger-count converter. Accepts Hamming-protected codewords over a valid/ready interface and corrects single-bit errors. Maps the recovered K-bit finger pattern to a count 1..2K (0 = no match) through a 2-stage pipeline. Keeps saturating error statistics for the system status block.

Parameters:
K, 5, number of fingers (info bits); legal range 2..11
P, derived, parity bits = smallest P with 2^P >= K+P+1 (K=5 -> 4)
CW_W, derived, codeword width = K+P (K=5 -> 9)
RES_W, derived, result width = clog2(2K+1) (K=5 -> 4)
CNT_W, 8, width of the statistics counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  codeword present
in_ready  out  1  block accepts the codeword this cycle
in_cw  in  CW_W  codeword; in_cw[i-1] = Hamming position i
out_valid  out  1  result present
out_ready  in  1  downstream accepts the result
out_result  out  RES_W  finger count, or 0 if no match
out_corrected  out  1  a single-bit error was corrected
out_uncorr  out  1  syndrome is out of range (uncorrectable)
out_invalid  out  1  decoded data is not a finger pattern
clr_stats  in  1  synchronous clear of both counters
cnt_corrected  out  CNT_W  saturating count of corrected words
cnt_uncorr  out  CNT_W  saturating count of uncorrectable words

Behaviour:
- Codeword layout: parity bits sit at positions 2^j. Data bits fill the remaining positions in ascending order, so info[0] is at position 3. For K=5, data sits at positions 3,5,6,7,9.
- Syndrome: XOR of the indices of all set positions (P bits).
  - 0: no error.
  - 1..CW_W: flip that position and assert corrected.
  - >CW_W: uncorr=1; out_result=0; corrected=0; invalid=0.
- Mapping (info[0]=LSB):
  - Thermometer filling from the LSB with n ones (n=1..K): result n.
  - Pattern with the low m bits cleared and the rest set (m=1..K-1): result K+m.
  - All zeros: result 2K.
  - Any other pattern: result 0, invalid=1.
- Stage 1 registers the syndrome and raw data. Stage 2 registers the corrected data, the mapped result and the flags. Latency is 2 cycles from the accept edge to out_valid with no stall.
- Handshake:
  - Transfer occurs when valid && ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational).
  - Full throughput of 1 word/cycle.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - in_cw is sampled only on an accepted cycle.
- Counters:
  - Increment when a stage-2 word with corrected=1 (or uncorr=1) completes the output transfer.
  - They saturate at 2^CNT_W-1.
  - clr_stats wins over a simultaneous increment; that increment is dropped.
- Reset (any time, including mid-stream):
  - Both stage valids go to 0 and all out_* signals go to 0.
  - Counters go to 0 and in_ready goes to 1 once reset is released.
  - In-flight words are discarded.

Decomposition:
- Shared package fcd_pkg: the functions clog2, parity_count(K) and data_pos(K, idx), plus the syndrome encoding constant SYN_NONE=0.
- Sub-module fcd_map (combinational): K-bit pattern -> {result, invalid}; reusable by the legacy converter.

Test Plan:
- Clean words, K=5, out_ready=1, back to back:
  - in_cw=0x007 -> result 1.
  - in_cw=0x1FE -> result 5.
  - in_cw=0x000 -> result 10.
  - All three have corrected=0 and uncorr=0, appear 2 cycles after acceptance, one per cycle.
- Single-bit error: in_cw=0x1FF (position 1 of 0x1FE flipped) -> result 5, corrected=1; cnt_corrected 0->1 after the output transfer.
- Double error: in_cw=0x140 (positions 7 and 9 set, syndrome 14) -> result 0, uncorr=1, corrected=0; cnt_uncorr 0->1.
- Non-finger pattern: in_cw=0x1CD (info 11001, clean) -> result 0, invalid=1, corrected=0.
- Backpressure: stream 4 words, hold out_ready=0 for 5 cycles.
  - in_ready drops after 2 words are captured.
  - out_* stays stable during the stall.
  - All 4 results emerge in order with no loss or duplication.
- Saturation, clear and reset:
  - Send 260 x 0x1FF with CNT_W=8 -> cnt_corrected=255.
  - Assert clr_stats together with a completing corrected word -> counter reads 0.
  - Assert rst_n=0 mid-stream -> out_valid=0 immediately; in_ready=1 after release.
